// File: rtl/vproc_pkg.sv
// Shared vproc types: memory arbiter master IDs and a small helper.
// Imported by the memory arbiter and its ID queue.
package vproc_pkg;

    typedef logic mem_arb_id_t;

    localparam mem_arb_id_t MEM_ARB_M_ICACHE = 1'b0;
    localparam mem_arb_id_t MEM_ARB_M_DCACHE = 1'b1;

    function automatic mem_arb_id_t mem_arb_other(input mem_arb_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/vproc_mem_arb_idq.sv
// In-order master ID queue for the memory arbiter.
// Records which master issued each accepted request.
module vproc_mem_arb_idq
    import vproc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  mem_arb_id_t id_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output mem_arb_id_t head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    mem_arb_id_t      ids_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = ids_q[rptr_q];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ids_q[i] <= MEM_ARB_M_ICACHE;
            end
        end else begin
            if (do_push) begin
                ids_q[wptr_q] <= id_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push != do_pop) begin
                cnt_q <= do_push ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Two-master memory arbiter (I-fetch = m0, D-cache = m1) with burst lock.
// VPROC_MEM_ARB_RR_EN selects round-robin tie-break; default is m1 priority.
module vproc_mem_arbiter
    import vproc_pkg::*;
#(
    parameter int unsigned ADDR_BIT_W      = 32,
    parameter int unsigned MEM_BYTE_W      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    input  logic [ADDR_BIT_W-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [MEM_BYTE_W*8-1:0] m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [MEM_BYTE_W*8-1:0] m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    input  logic [ADDR_BIT_W-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [MEM_BYTE_W*8-1:0] m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [MEM_BYTE_W*8-1:0] m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    mem_req_o,
    output logic [ADDR_BIT_W-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [MEM_BYTE_W*8-1:0] mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [MEM_BYTE_W*8-1:0] mem_rdata_i,
    input  logic                    mem_err_i
);

    mem_arb_id_t owner_q, owner_d;
    logic        lock_q, lock_d;
    mem_arb_id_t last_q, last_d;

    mem_arb_id_t sel;
    mem_arb_id_t tie;
    mem_arb_id_t head;
    logic        sel_req;
    logic        owner_req;
    logic        full;
    logic        empty;
    logic        accept;
    logic        pop;

`ifdef VPROC_MEM_ARB_RR_EN
    assign tie = mem_arb_other(last_q);
`else
    assign tie = MEM_ARB_M_DCACHE;
`endif

    assign owner_req = (owner_q == MEM_ARB_M_DCACHE) ? m1_req_i : m0_req_i;
    assign sel_req   = m0_req_i | m1_req_i;

    always_comb begin
        sel = MEM_ARB_M_ICACHE;
        if (lock_q && owner_req) begin
            sel = owner_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = tie;
        end else if (m1_req_i) begin
            sel = MEM_ARB_M_DCACHE;
        end
    end

    // No bypass: a full queue blocks requests even when a pop is in flight
    assign mem_req_o = sel_req & ~full & ~rst_i;
    assign accept    = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            if (sel == MEM_ARB_M_DCACHE) begin
                mem_addr_o  = m1_addr_i;
                mem_we_o    = m1_we_i;
                mem_wdata_o = m1_wdata_i;
            end else begin
                mem_addr_o  = m0_addr_i;
                mem_we_o    = m0_we_i;
                mem_wdata_o = m0_wdata_i;
            end
        end
    end

    assign m0_gnt_o = accept & (sel == MEM_ARB_M_ICACHE);
    assign m1_gnt_o = accept & (sel == MEM_ARB_M_DCACHE);

    assign pop         = mem_rvalid_i & ~empty & ~rst_i;
    assign m0_rvalid_o = pop & (head == MEM_ARB_M_ICACHE);
    assign m1_rvalid_o = pop & (head == MEM_ARB_M_DCACHE);
    assign m0_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign m1_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign m0_err_o    = mem_err_i & ~rst_i;
    assign m1_err_o    = mem_err_i & ~rst_i;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            lock_d  = 1'b1;
            owner_d = sel;
            last_d  = sel;
        end else if (lock_q && !owner_req) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q  <= 1'b0;
            owner_q <= MEM_ARB_M_ICACHE;
            last_q  <= MEM_ARB_M_DCACHE;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    vproc_mem_arb_idq #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_idq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .id_i    (sel),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; flag it loudly
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_rvalid_i) begin
            assert (!empty)
            else $warning("vproc_mem_arbiter: response with no outstanding request dropped");
        end
    end
`endif

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// Scoreboard bench for vproc_mem_arbiter: expected grants/responses are
// queued by the stimulus and consumed by an independent monitor.
module tb_vproc_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic gq[$];
    rsp_t rq[$];
    int   n_chk = 0;
    int   n_pass = 0;

`ifdef VPROC_MEM_ARB_RR_EN
    int r0s[5] = '{1, 0, 1, 0, 0};
    int r1s[5] = '{1, 1, 0, 1, 0};
    int gs[4]  = '{0, 1, 0, 1};
`else
    int r0s[5] = '{1, 1, 0, 1, 0};
    int r1s[5] = '{1, 0, 1, 0, 0};
    int gs[4]  = '{1, 0, 1, 0};
`endif

    always #5 clk_i = ~clk_i;

    vproc_mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_we_i      (m0_we_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_err_o     (m0_err_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_we_i      (m1_we_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_err_o     (m1_err_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reqs(input int r0, input int r1);
        m0_req_i = (r0 != 0);
        m1_req_i = (r1 != 0);
    endtask

    task automatic exp_gnt(input int id);
        gq.push_back(id != 0);
    endtask

    task automatic give_rsp(input int id, input logic [31:0] d, input logic e);
        rsp_t r;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_err_i    = e;
        r.id = (id != 0);
        r.d  = d;
        r.e  = e;
        rq.push_back(r);
    endtask

    task automatic no_rsp();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
    endtask

    // Monitor: consumes expectations whenever the DUT shows a grant or response
    initial begin
        forever begin
            @(negedge clk_i);
            if (m0_gnt_o || m1_gnt_o) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {m1_gnt_o, m0_gnt_o}, 0);
                end else begin
                    logic g;
                    g = gq.pop_front();
                    chk("gnt_id", {m1_gnt_o, m0_gnt_o}, g ? 2'b10 : 2'b01);
                end
            end
            if (m0_rvalid_o || m1_rvalid_o) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_vld", {m1_rvalid_o, m0_rvalid_o}, r.id ? 2'b10 : 2'b01);
                    chk("rsp_m0", {m0_err_o, m0_rdata_o}, {r.e, r.d});
                    chk("rsp_m1", {m1_err_o, m1_rdata_o}, {r.e, r.d});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        reqs(0, 1);
        m0_addr_i = 32'h0; m0_we_i = 1'b0; m0_wdata_i = 32'h0;
        m1_addr_i = 32'h44; m1_we_i = 1'b1; m1_wdata_i = 32'h55;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55; mem_err_i = 1'b1;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_m1_gnt", m1_gnt_o, 0);
        chk("rst_m1_rvalid", m1_rvalid_o, 0);
        chk("rst_m1_rdata", {m1_err_o, m1_rdata_o}, 0);
        step();
        step();
        rst_i = 1'b0;
        reqs(0, 0);
        m1_we_i = 1'b0; m1_wdata_i = 32'h0;
        no_rsp();
        step();

        // Tie-break with single-beat requests, starting from last_q = m1
        m0_addr_i = 32'h1000; m1_addr_i = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            reqs(r0s[i], r1s[i]);
            if (i < 4) exp_gnt(gs[i]);
            if (i > 0) give_rsp(gs[i-1], 32'h10 + 32'(i), 1'b0);
            else no_rsp();
            #1;
            if (i == 0) chk("tie_addr", mem_addr_o, gs[0] != 0 ? 32'h2000 : 32'h1000);
            step();
        end
        reqs(0, 0); no_rsp(); step();

        // Responses routed in issue order: m0, m1, m0
        m0_addr_i = 32'h100; reqs(1, 0); exp_gnt(0);
        #1; chk("ord_addr0", mem_addr_o, 32'h100);
        step();
        m1_addr_i = 32'h104; m1_we_i = 1'b1; m1_wdata_i = 32'hDEAD;
        reqs(0, 1); exp_gnt(1);
        #1; chk("ord_we_wdata", {mem_we_o, mem_wdata_o}, {1'b1, 32'hDEAD});
        step();
        m1_we_i = 1'b0; m0_addr_i = 32'h108; reqs(1, 0); exp_gnt(0);
        step();
        reqs(0, 0); step();
        give_rsp(0, 32'hA, 1'b0); step();
        give_rsp(1, 32'hB, 1'b1); step();
        give_rsp(0, 32'hC, 1'b0); step();
        no_rsp(); step();

        // m1 four-word burst fills the queue; full blocks even with a pop
        for (int i = 0; i < 4; i++) begin
            m1_addr_i = 32'h200 + 32'(4 * i);
            reqs(0, 1); exp_gnt(1);
            #1; chk("burst_addr", mem_addr_o, 32'h200 + 32'(4 * i));
            step();
        end
        m1_addr_i = 32'h210;
        #1; chk("full_no_req", {mem_req_o, m1_gnt_o}, 0);
        step();
        give_rsp(1, 32'h21, 1'b0);
        #1; chk("full_pop_no_req", {mem_req_o, m1_gnt_o}, 0);
        step();
        no_rsp(); exp_gnt(1);
        #1; chk("after_pop_req", mem_req_o, 1);
        step();
        reqs(0, 0);
        for (int i = 0; i < 4; i++) begin
            give_rsp(1, 32'h22 + 32'(i), 1'b0);
            step();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
        #1; chk("empty_drop", {m1_rvalid_o, m0_rvalid_o}, 0);
        step();
        no_rsp(); step();

        // Locked m1 burst keeps m0 out until m1 drops req
        m0_addr_i = 32'h400; m1_addr_i = 32'h500;
        reqs(0, 1); exp_gnt(1); step();
        for (int i = 0; i < 3; i++) begin
            reqs(1, 1); exp_gnt(1); give_rsp(1, 32'h31 + 32'(i), 1'b0);
            step();
        end
        reqs(1, 0); exp_gnt(0); give_rsp(1, 32'h34, 1'b0);
        #1; chk("unlock_addr", mem_addr_o, 32'h400);
        step();
        reqs(0, 0); give_rsp(0, 32'h35, 1'b0); step();
        no_rsp(); step();

        // Reset with two outstanding m0 requests
        m0_addr_i = 32'h300; reqs(1, 0); exp_gnt(0); step();
        m0_addr_i = 32'h304; exp_gnt(0); step();
        rst_i = 1'b1;
        reqs(1, 1); m1_we_i = 1'b1; m1_wdata_i = 32'hBEEF;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77; mem_err_i = 1'b1;
        #1;
        chk("rst2_req", {mem_req_o, m0_gnt_o, m1_gnt_o}, 0);
        chk("rst2_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        chk("rst2_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
        chk("rst2_rdata", {m0_err_o, m1_err_o, m0_rdata_o, m1_rdata_o}, 0);
        step();
        rst_i = 1'b0; reqs(0, 0); m1_we_i = 1'b0; m1_wdata_i = 32'h0;
        mem_rdata_i = 32'h78; mem_err_i = 1'b0;
        #1; chk("post_rst_drop", {m1_rvalid_o, m0_rvalid_o}, 0);
        step();
        no_rsp();
        m0_addr_i = 32'h308; reqs(1, 0); exp_gnt(0);
        #1; chk("post_rst_addr", mem_addr_o, 32'h308);
        step();
        reqs(0, 0); give_rsp(0, 32'h79, 1'b0); step();
        no_rsp(); step(); step();

        chk("gnt_queue_drained", 80'(gq.size()), 0);
        chk("rsp_queue_drained", 80'(rq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
